// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: FSM state encoding, transaction owner encoding and default bus
// widths shared by the arbiter, its streak counter and the CPU top.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wide enough for the largest legal MAX_DM_STREAK (15).
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// rtl/mem_port_arbiter_streak_counter.sv - grant decision plus DM streak counter
//
// Purpose: decides which requester wins the port when the arbiter is idle.
// DM has fixed priority, except that after MAX_DM_STREAK consecutive DM
// grants taken while IF was waiting, the next grant goes to IF.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   arb_en_i       arbiter is in IDLE and may grant this cycle
//   if_req_i       instruction fetch request
//   dm_req_i       data memory request
//   grant_dm_o     DM wins this cycle (only while arb_en_i)
//   grant_if_o     IF wins this cycle (only while arb_en_i)
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic grant_dm_o,
  output logic grant_if_o
);

  localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  always_comb begin
    grant_dm_o = arb_en_i & dm_req_i & (~if_req_i | (streak_q < MAX_C));
    grant_if_o = arb_en_i & if_req_i & ~grant_dm_o;

    streak_d = streak_q;
    if (grant_dm_o) begin
      // Only DM grants that actually made IF wait count toward the streak.
      if (if_req_i) begin
        streak_d = (streak_q < MAX_C) ? streak_q + STREAK_W'(1) : streak_q;
      end else begin
        streak_d = '0;
      end
    end else if (grant_if_o) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one shared multi-cycle memory port
//
// Purpose: grants the backing memory port to instruction fetch or the data
// stage, holds the latched request stable until the memory acknowledges,
// then returns registered read data with a one-cycle ack to the owner.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   if_req_i, if_addr_i              fetch request (held until if_ack_o)
//   if_rdata_o, if_ack_o             fetch data and completion pulse
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                       data request (held until dm_ack_o)
//   dm_rdata_o, dm_ack_o             load data and completion pulse
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                      backing-port request, stable while in flight
//   mem_rdata_i, mem_ack_i           backing-port completion
//   stall_o                          pipeline stall while any request is open
//   proto_err_o                      sticky protocol-error flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              proto_err_o
);

  arb_state_e        state_q,     state_d;
  owner_e            owner_q,     owner_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              dm_ack_q,    dm_ack_d;
  logic              proto_err_q, proto_err_d;

  logic grant_dm;
  logic grant_if;
  logic owner_req;

  arb_streak_counter #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_streak (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arb_en_i  (state_q == ST_IDLE),
    .if_req_i  (if_req_i),
    .dm_req_i  (dm_req_i),
    .grant_dm_o(grant_dm),
    .grant_if_o(grant_if)
  );

  // The owner must keep its request up until it has seen its ack.
  assign owner_req = (owner_q == OWN_DM) ? dm_req_i : if_req_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_ack_i) begin
          proto_err_d = 1'b1;
        end
        if (grant_dm) begin
          state_d     = ST_BUS;
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (grant_if) begin
          state_d     = ST_BUS;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end

      ST_BUS: begin
        if (!owner_req) begin
          proto_err_d = 1'b1;
        end
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          // Ack is registered so it lines up with the RESP cycle.
          if (owner_q == OWN_DM) begin
            dm_rdata_d = mem_rdata_i;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        if (mem_ack_i || !owner_req) begin
          proto_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign proto_err_o = proto_err_q;

  // Stall drops in the ack cycle so the pipeline advances exactly once.
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        proto_err_o;

  logic mdl_ack;
  logic inj_ack;
  assign mem_ack_i = mdl_ack | inj_ack;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ack_o   (if_ack_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_ack_o   (dm_ack_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .stall_o    (stall_o),
    .proto_err_o(proto_err_o)
  );

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 2;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_dm_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic void push_rsp(input bit d, input logic [31:0] v);
    rsp_t r;
    r.is_dm = d;
    r.rdata = v;
    rsp_q.push_back(r);
  endfunction

  function automatic void push_mem(input logic we, input logic [31:0] a, input logic [31:0] w);
    mreq_t m;
    m.we    = we;
    m.addr  = a;
    m.wdata = w;
    mreq_q.push_back(m);
  endfunction

  // Contents of the backing memory as seen by this bench.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  // Backing memory: acks mem_lat cycles after mem_req_o rises, checks the
  // request against the expected queue and its stability while in flight.
  initial begin : mem_model
    logic [31:0] a;
    logic [31:0] w;
    logic        we;
    int          k;
    bit          alive;
    mreq_t       m;
    mdl_ack     = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i && mem_req_o) begin
        a  = mem_addr_o;
        w  = mem_wdata_o;
        we = mem_we_o;
        if (mreq_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req addr=%h expected none", a);
        end else begin
          m = mreq_q.pop_front();
          chk1("mem_we", we, m.we);
          chk("mem_addr", a, m.addr);
          if (m.we) chk("mem_wdata", w, m.wdata);
        end
        k     = 1;
        alive = 1'b1;
        while (k < mem_lat && alive) begin
          @(posedge clk);
          #1;
          if (!mem_req_o) begin
            alive = 1'b0;
          end else begin
            chk("addr_stable", mem_addr_o, a);
            chk("wdata_stable", mem_wdata_o, w);
            chk1("we_stable", mem_we_o, we);
          end
          k++;
        end
        if (alive) begin
          mem_rdata_i = mem_data(a);
          mdl_ack     = 1'b1;
          @(posedge clk);
          #1;
          mdl_ack = 1'b0;
          chk1("mem_req_drop", mem_req_o, 1'b0);
        end
      end
    end
  end

  // Response monitor: every ack pops one expected response.
  always @(negedge clk) begin : rsp_monitor
    rsp_t r;
    if (!rst_i && (if_ack_o || dm_ack_o)) begin
      chk1("ack_single", if_ack_o & dm_ack_o, 1'b0);
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack if_ack=%b dm_ack=%b expected none", if_ack_o, dm_ack_o);
      end else begin
        r = rsp_q.pop_front();
        chk1("ack_is_dm", dm_ack_o, r.is_dm);
        if (r.is_dm) begin
          chk("dm_rdata", dm_rdata_o, r.rdata);
          chk("if_rdata_held", if_rdata_o, exp_if_rdata);
          exp_dm_rdata = r.rdata;
        end else begin
          chk("if_rdata", if_rdata_o, r.rdata);
          chk("dm_rdata_held", dm_rdata_o, exp_dm_rdata);
          exp_if_rdata = r.rdata;
        end
      end
    end
  end

  // Raise a request, hold it until its ack, optionally drop it early.
  task automatic do_req(input bit is_dm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit solo, input int drop_after);
    int n       = 0;
    bit dropped = 1'b0;
    bit got     = 1'b0;
    if (is_dm) begin
      dm_req_i   = 1'b1;
      dm_we_i    = we;
      dm_addr_i  = addr;
      dm_wdata_i = wdata;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end
    while (!got && n < 300) begin
      @(negedge clk);
      if (is_dm ? dm_ack_o : if_ack_o) begin
        got = 1'b1;
        if (solo) chk1("stall_ack_cycle", stall_o, 1'b0);
      end else begin
        if (!dropped) chk1("stall_pending", stall_o, 1'b1);
        n++;
        if (n == drop_after) begin
          dropped = 1'b1;
          if (is_dm) dm_req_i = 1'b0;
          else       if_req_i = 1'b0;
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout addr=%h got=0 expected=1", addr);
    end
    @(posedge clk);
    #1;
    if (is_dm) dm_req_i = 1'b0;
    else       if_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rst_i      = 1'b1;
    inj_ack    = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = 32'h0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_addr_i  = 32'h0;
    dm_wdata_i = 32'h0;

    repeat (2) @(negedge clk);
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk1("rst_if_ack", if_ack_o, 1'b0);
    chk1("rst_dm_ack", dm_ack_o, 1'b0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_proto_err", proto_err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(1);

    // IF-only read, memory acks two cycles after mem_req_o.
    mem_lat = 2;
    push_mem(1'b0, 32'h40, 32'h0);
    push_rsp(1'b0, 32'h0050_0093);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 0);
    idle(2);

    // Simultaneous requests: DM write first, then IF.
    push_mem(1'b1, 32'h100, 32'hDEAD_BEEF);
    push_mem(1'b0, 32'h44, 32'h0);
    push_rsp(1'b1, 32'hC0DE_0100);
    push_rsp(1'b0, 32'hC0DE_0044);
    fork
      do_req(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 0);
      do_req(1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 0);
    join
    idle(2);

    // Starvation guard: DM,DM,DM,DM,IF,DM.
    push_mem(1'b0, 32'h300, 32'h0);
    push_mem(1'b0, 32'h304, 32'h0);
    push_mem(1'b0, 32'h308, 32'h0);
    push_mem(1'b0, 32'h30C, 32'h0);
    push_mem(1'b0, 32'h80, 32'h0);
    push_mem(1'b0, 32'h310, 32'h0);
    push_rsp(1'b1, 32'hC0DE_0300);
    push_rsp(1'b1, 32'hC0DE_0304);
    push_rsp(1'b1, 32'hC0DE_0308);
    push_rsp(1'b1, 32'hC0DE_030C);
    push_rsp(1'b0, 32'hC0DE_0080);
    push_rsp(1'b1, 32'hC0DE_0310);
    fork
      begin
        for (int i = 0; i < 5; i++) do_req(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b0, 0);
      end
      do_req(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 0);
    join
    idle(2);

    // Variable memory latency.
    mem_lat = 1;
    push_mem(1'b1, 32'h500, 32'h1111_2222);
    push_rsp(1'b1, 32'hC0DE_0500);
    do_req(1'b1, 1'b1, 32'h500, 32'h1111_2222, 1'b1, 0);
    mem_lat = 5;
    push_mem(1'b0, 32'h504, 32'h0);
    push_rsp(1'b0, 32'hC0DE_0504);
    do_req(1'b0, 1'b0, 32'h504, 32'h0, 1'b1, 0);
    mem_lat = 20;
    push_mem(1'b1, 32'h508, 32'hCAFE_F00D);
    push_rsp(1'b1, 32'hC0DE_0508);
    do_req(1'b1, 1'b1, 32'h508, 32'hCAFE_F00D, 1'b1, 0);
    idle(2);

    // Stray memory ack in IDLE.
    @(negedge clk);
    chk1("proto_err_clean", proto_err_o, 1'b0);
    @(posedge clk);
    #1;
    inj_ack = 1'b1;
    @(posedge clk);
    #1;
    inj_ack = 1'b0;
    @(negedge clk);
    chk1("proto_err_idle_ack", proto_err_o, 1'b1);
    chk1("idle_ack_no_grant", mem_req_o, 1'b0);
    repeat (3) @(negedge clk);
    chk1("proto_err_sticky", proto_err_o, 1'b1);
    chk1("idle_ack_still_idle", mem_req_o, 1'b0);

    // Reset while a DM read is in flight.
    mem_lat = 20;
    push_mem(1'b0, 32'h600, 32'h0);
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h600;
    dm_req_i  = 1'b1;
    n = 0;
    while (!mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("mid_bus_req_up", mem_req_o, 1'b1);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk1("async_mem_req_drop", mem_req_o, 1'b0);
    chk1("reset_clears_proto_err", proto_err_o, 1'b0);
    chk1("reset_no_dm_ack", dm_ack_o, 1'b0);
    dm_req_i     = 1'b0;
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    @(negedge clk);
    chk("reset_if_rdata", if_rdata_o, 32'h0);
    chk("reset_dm_rdata", dm_rdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(1);
    mem_lat = 3;
    push_mem(1'b0, 32'h604, 32'h0);
    push_rsp(1'b1, 32'hC0DE_0604);
    do_req(1'b1, 1'b0, 32'h604, 32'h0, 1'b1, 0);
    @(negedge clk);
    chk1("post_reset_no_err", proto_err_o, 1'b0);
    idle(1);

    // DM drops its request mid-BUS: ack still pulses, error latched.
    mem_lat = 5;
    push_mem(1'b1, 32'h700, 32'h1234_5678);
    push_rsp(1'b1, 32'hC0DE_0700);
    do_req(1'b1, 1'b1, 32'h700, 32'h1234_5678, 1'b1, 3);
    @(negedge clk);
    chk1("proto_err_dropped_req", proto_err_o, 1'b1);

    idle(4);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    chk("mem_queue_drained", 32'(mreq_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
